// File: rtl/riscv_mem_pkg.sv
// Shared data-memory types for the RISC-V core data path.
// Provides the default address/data widths and the store-buffer entry layout.
package riscv_mem_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/dmem_sb_match.sv
// Youngest-first address match over the store-buffer entry array.
// Scans from tail-1 back towards the oldest slot; the first valid entry whose
// full address equals addr_i supplies the forwarded data.
module dmem_sb_match
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t            entries_i [DEPTH],
    input  logic [PTR_W-1:0]     tail_i,
    input  logic [SB_ADDR_W-1:0] addr_i,
    output logic                 hit_o,
    output logic [SB_DATA_W-1:0] data_o
);

    logic [PTR_W-1:0] idx;

    // Priority search, youngest entry first; offset DEPTH wraps onto tail itself (oldest when full).
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            idx = tail_i - PTR_W'(i);
            if (!hit_o && entries_i[idx].valid && (entries_i[idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and data memory.
// Stores retire into a DEPTH-entry FIFO and drain in order under MemWReady;
// loads forward from the youngest matching pending store, else read memory.
// Optional feature: define STORE_COALESCE_EN to merge a store into the youngest
// entry when the addresses match (no allocation, never stalls).
// ADDR_W/DATA_W must equal the riscv_mem_pkg widths used by sb_entry_t.
module dmem_store_buffer
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] DataMemAddr,
    input  logic              DataMemRead,
    input  logic              DataMemWrite,
    input  logic [DATA_W-1:0] DataMemWData,
    output logic [DATA_W-1:0] DataMemRData,
    output logic              DataMemStall,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemWAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemWReady,
    output logic [ADDR_W-1:0] MemRAddr,
    input  logic [DATA_W-1:0] MemRData,
    output logic              SbEmpty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    sb_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]  tail_prev;
    logic              full, pop, push, coalesce;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign SbEmpty   = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign MemWrite  = !SbEmpty;
    assign MemWAddr  = addr_q[head_q];
    assign MemWData  = data_q[head_q];
    assign pop       = MemWrite && MemWReady;
    assign tail_prev = tail_q - PTR_W'(1);

`ifdef STORE_COALESCE_EN
    // Merge into the youngest entry unless that entry is the one leaving this cycle.
    assign coalesce = DataMemWrite && !SbEmpty && (addr_q[tail_prev] == DataMemAddr)
                      && !(pop && (count_q == CNT_W'(1)));
`else
    assign coalesce = 1'b0;
`endif

    // A full buffer still accepts a store when the head drains in the same cycle.
    assign DataMemStall = DataMemWrite && full && !pop && !coalesce;
    assign push         = DataMemWrite && !DataMemStall && !coalesce;

    // Pack the storage into entry records for the forwarding matcher.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = '{valid: valid_q[i], addr: addr_q[i], data: data_q[i]};
        end
    end

    dmem_sb_match #(.DEPTH(DEPTH)) u_match (
        .entries_i (entries),
        .tail_i    (tail_q),
        .addr_i    (DataMemAddr),
        .hit_o     (fwd_hit),
        .data_o    (fwd_data)
    );

    assign MemRAddr     = DataMemAddr;
    assign DataMemRData = DataMemRead ? (fwd_hit ? fwd_data : MemRData) : '0;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop)  head_d = head_q + PTR_W'(1);
        if (push) tail_d = tail_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state: pointers, count and valid bits, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Push after pop: on a full push+pop head==tail and the slot must stay valid.
            if (pop)  valid_q[head_q] <= 1'b0;
            if (push) valid_q[tail_q] <= 1'b1;
        end
    end

    // Entry payload: written on push, or overwritten in place on coalesce.
    always_ff @(posedge CLK) begin
        // NOTE: payload storage is not reset; valid bits and count alone decide whether it is ever observed.
        if (push) begin
            addr_q[tail_q] <= DataMemAddr;
            data_q[tail_q] <= DataMemWData;
        end else if (coalesce) begin
            data_q[tail_prev] <= DataMemWData;
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed scenarios plus random
// traffic against a queue-based reference model; a separate monitor checks the
// drain stream against a scoreboard of accepted stores.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [AW-1:0] DataMemAddr = '0;
    logic          DataMemRead = 1'b0;
    logic          DataMemWrite = 1'b0;
    logic [DW-1:0] DataMemWData = '0;
    logic [DW-1:0] DataMemRData;
    logic          DataMemStall;
    logic          MemWrite;
    logic [AW-1:0] MemWAddr;
    logic [DW-1:0] MemWData;
    logic          MemWReady = 1'b0;
    logic [AW-1:0] MemRAddr;
    logic [DW-1:0] MemRData = '0;
    logic          SbEmpty;

    dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .DataMemAddr  (DataMemAddr),
        .DataMemRead  (DataMemRead),
        .DataMemWrite (DataMemWrite),
        .DataMemWData (DataMemWData),
        .DataMemRData (DataMemRData),
        .DataMemStall (DataMemStall),
        .MemWrite     (MemWrite),
        .MemWAddr     (MemWAddr),
        .MemWData     (MemWData),
        .MemWReady    (MemWReady),
        .MemRAddr     (MemRAddr),
        .MemRData     (MemRData),
        .SbEmpty      (SbEmpty)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } st_t;

    st_t model_q[$];   // reference: stores accepted but not yet written to memory, oldest first
    st_t exp_q[$];     // scoreboard: expected drain sequence, consumed by the monitor
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT offers a drain, it must match the oldest expected store.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST && MemWrite) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL drain_unexpected: MemWrite=1 addr 0x%0h, expected no pending store", MemWAddr);
                end else begin
                    check("drain_addr", MemWAddr, exp_q[0].addr);
                    check("drain_data", MemWData, exp_q[0].data);
                    if (MemWReady) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic rd, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] mem_val, input logic rdy);
        int            n;
        logic          pop_e, coal_e, stall_e;
        logic [DW-1:0] exp_rd;
        st_t           e;
        DataMemRead  = rd;
        DataMemWrite = wr;
        DataMemAddr  = addr;
        DataMemWData = wdata;
        MemRData     = mem_val;
        MemWReady    = rdy;
        @(negedge CLK);
        n      = model_q.size();
        pop_e  = (n > 0) && rdy;
        coal_e = 1'b0;
`ifdef STORE_COALESCE_EN
        coal_e = wr && (n > 0) && (model_q[n-1].addr == addr) && !(pop_e && (n == 1));
`endif
        stall_e = wr && (n == DEPTH) && !pop_e && !coal_e;
        exp_rd  = '0;
        if (rd) begin
            exp_rd = mem_val;
            for (int i = 0; i < n; i++)
                if (model_q[i].addr == addr) exp_rd = model_q[i].data;
        end
        check("stall", DataMemStall, stall_e);
        check("mem_write", MemWrite, n > 0);
        check("sb_empty", SbEmpty, n == 0);
        check("load_rdata", DataMemRData, exp_rd);
        check("mem_raddr", MemRAddr, addr);
        if (pop_e) void'(model_q.pop_front());
        if (coal_e) begin
            e = model_q.pop_back();
            e.data = wdata;
            model_q.push_back(e);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_back();
                e.data = wdata;
                exp_q.push_back(e);
            end
        end else if (wr && !stall_e) begin
            e.addr = addr;
            e.data = wdata;
            model_q.push_back(e);
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, '0, '0, $urandom, rdy);
    endtask

    logic [AW-1:0] addr_tab [6] = '{32'h3F0, 32'h3F4, 32'h3F8, 32'h3FC, 32'h100, 32'h104};

    initial begin
        // Reset state, with a store request held to show reset blocks stalls and drains.
        DataMemWrite = 1'b1;
        #3;
        check("rst_sb_empty", SbEmpty, 1'b1);
        check("rst_mem_write", MemWrite, 1'b0);
        check("rst_stall", DataMemStall, 1'b0);
        check("rst_rdata", DataMemRData, '0);
        DataMemWrite = 1'b0;
        #9 RST = 1'b1;
        @(posedge CLK);
        #1;

        // Store then load next cycle: forwarded value; MemWrite is a one-cycle pulse.
        cycle(1'b0, 1'b1, 32'h3F8, 32'h64, $urandom, 1'b1);
        cycle(1'b1, 1'b0, 32'h3F8, '0, 32'hBAD0, 1'b1);
        idle(1, 1'b1);

        // Fill with the memory stalled; the fifth store stalls until a drain frees a slot.
        cycle(1'b0, 1'b1, 32'h3F8, 32'h11, $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'h3FC, 32'h22, $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'h3F0, 32'h33, $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'h3F4, 32'h44, $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'h200, 32'h55, $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'h200, 32'h55, $urandom, 1'b1);
        idle(6, 1'b1);

        // Same address twice: the youngest store wins on a load.
        cycle(1'b0, 1'b1, 32'h3FC, 32'h5, $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'h3FC, 32'h4, $urandom, 1'b0);
        cycle(1'b1, 1'b0, 32'h3FC, '0, 32'hAAAA, 1'b0);
        idle(4, 1'b1);

        // Full buffer: push and pop together is accepted, occupancy stays at DEPTH.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 32'h300 + 32'(4 * i), 32'h70 + 32'(i), $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'h310, 32'h80, $urandom, 1'b1);
        cycle(1'b0, 1'b1, 32'h314, 32'h81, $urandom, 1'b0);
        cycle(1'b1, 1'b0, 32'h310, '0, 32'h1234, 1'b0);
        idle(6, 1'b1);

        // Load miss reads memory; no read request returns zero.
        cycle(1'b1, 1'b0, 32'h100, '0, 32'hDEAD, 1'b1);
        cycle(1'b0, 1'b0, 32'h100, '0, 32'hDEAD, 1'b1);

        // Asynchronous reset mid-drain discards pending stores immediately.
        cycle(1'b0, 1'b1, 32'h400, 32'h1, $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'h404, 32'h2, $urandom, 1'b0);
        cycle(1'b0, 1'b1, 32'h408, 32'h3, $urandom, 1'b0);
        DataMemWrite = 1'b0;
        MemWReady    = 1'b1;
        #2 RST = 1'b0;
        #1;
        check("async_rst_sb_empty", SbEmpty, 1'b1);
        check("async_rst_mem_write", MemWrite, 1'b0);
        model_q.delete();
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        idle(2, 1'b1);

        // Random traffic: mixed loads, stores and memory backpressure.
        for (int i = 0; i < 500; i++) begin
            logic          wr, rd, rdy;
            logic [AW-1:0] a;
            wr  = ($urandom_range(0, 9) < 6);
            rd  = !wr && ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 9) < 4);
            a   = addr_tab[$urandom_range(0, 5)];
            cycle(rd, wr, a, $urandom, $urandom, rdy);
        end

        // Bounded final drain.
        for (int i = 0; i < 4 * DEPTH && model_q.size() > 0; i++) idle(1, 1'b1);
        idle(1, 1'b1);
        check("final_sb_empty", SbEmpty, 1'b1);
        check("scoreboard_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
